// File: rtl/calc_pkg.sv
// calc_pkg: key codes, FSM state encoding and operator encoding shared by the
// calculator engine and its divider.
package calc_pkg;

  localparam logic [3:0] KEY_DIV = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [3:0] KEY_ADD = 4'd12;
  localparam logic [3:0] KEY_SUB = 4'd13;
  localparam logic [3:0] KEY_MUL = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;

  typedef enum logic [2:0] {
    ENT_A,
    OP_WAIT,
    ENT_B,
    DIV_RUN,
    SHOW_RES,
    ERROR
  } calc_state_t;

  // Map an operator key to its cur_op code; anything else is OP_NONE
  function automatic logic [2:0] key_to_op(input logic [3:0] k);
    case (k)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_NONE;
    endcase
  endfunction

  // 10^n, used to derive the display range limit at elaboration time
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/calc_div.sv
// calc_div: unsigned restoring divider, one quotient bit per cycle.
// done and quotient are presented combinationally during the last step so the
// caller can register the result on the same edge the final bit is formed.
module calc_div
  import calc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic          running;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dsr;
  logic [W:0]    rem_sh;
  logic [W:0]    diff;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  quo_step;

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative
  always_comb begin
    rem_sh = {rem, quo[W-1]};
    diff   = rem_sh - {1'b0, dsr};
    if (diff[W]) begin
      rem_step = rem_sh[W-1:0];
      quo_step = {quo[W-2:0], 1'b0};
    end else begin
      rem_step = diff[W-1:0];
      quo_step = {quo[W-2:0], 1'b1};
    end
  end

  assign done     = running && (cnt == CW'(1));
  assign quotient = quo_step;

  // Iteration registers; abort throws away a division in progress
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dsr     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CW'(W);
      rem     <= '0;
      quo     <= dividend;
      dsr     <= divisor;
    end else if (running) begin
      rem <= rem_step;
      quo <= quo_step;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// calc_engine: keypad-driven four-function calculator core.
// Build macro CALC_KEY_FIFO_EN adds a 2-entry queue that holds keys pressed
// while the divider runs and replays them once it finishes.
module calc_engine
  import calc_pkg::*;
#(
  parameter int ENT_DIGITS  = 4,
  parameter int DISP_DIGITS = 8,
  parameter int RES_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key_val,
  input  logic                    key_pressed,
  output logic signed [RES_W-1:0] disp_val,
  output logic [2:0]              cur_op,
  output logic                    err,
  output logic                    busy,
  output logic                    key_drop
);

  localparam int CNT_W = $clog2(ENT_DIGITS + 1);
  localparam int WW    = 2 * RES_W;
  localparam logic signed [WW-1:0] RES_LIMIT = WW'(pow10(DISP_DIGITS) - 64'd1);

  calc_state_t             state, state_nxt;
  logic signed [RES_W-1:0] a, a_nxt, b, b_nxt, disp_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [2:0]              op_nxt, pend_op, pend_op_nxt, fin_op;
  logic                    pend_chain, pend_chain_nxt, div_neg, div_neg_nxt;
  logic                    err_nxt, busy_nxt, drop_nxt;
  logic                    fin, fin_chain;
  logic signed [WW-1:0]    fin_res;

  logic       ev;
  logic [3:0] key;
  logic       clr_ev;

  assign clr_ev = key_pressed && (key_val == KEY_CLR);

`ifdef CALC_KEY_FIFO_EN
  logic [3:0] q_key [2];
  logic [1:0] q_cnt;
  logic       q_push, q_pop;

  // Pick the key to act on: queued keys first, new keys parked while dividing
  always_comb begin
    ev       = 1'b0;
    key      = key_val;
    drop_nxt = 1'b0;
    q_push   = 1'b0;
    q_pop    = 1'b0;
    if (clr_ev) begin
      ev = 1'b1;
    end else if (state == DIV_RUN) begin
      if (key_pressed) begin
        if (q_cnt == 2'd2) drop_nxt = 1'b1;
        else               q_push   = 1'b1;
      end
    end else if (q_cnt != 2'd0) begin
      ev     = 1'b1;
      key    = q_key[0];
      q_pop  = 1'b1;
      q_push = key_pressed;
    end else begin
      ev = key_pressed;
    end
  end

  // Queue storage in arrival order; 'C' flushes it
  always_ff @(posedge clk) begin
    if (rst || clr_ev) begin
      q_cnt    <= '0;
      q_key[0] <= '0;
      q_key[1] <= '0;
    end else begin
      case ({q_push, q_pop})
        2'b01: begin
          q_key[0] <= q_key[1];
          q_cnt    <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q_key[0] <= key_val;
          end else begin
            q_key[0] <= q_key[1];
            q_key[1] <= key_val;
          end
        end
        2'b10: begin
          if (q_cnt == 2'd0) q_key[0] <= key_val;
          else               q_key[1] <= key_val;
          q_cnt <= q_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end
`else
  // Without a queue, anything but 'C' pressed during a divide is discarded
  always_comb begin
    ev       = key_pressed;
    key      = key_val;
    drop_nxt = 1'b0;
    if (!clr_ev && (state == DIV_RUN) && key_pressed) begin
      ev       = 1'b0;
      drop_nxt = 1'b1;
    end
  end
`endif

  logic                    is_digit, is_eq;
  logic [2:0]              key_op;
  logic signed [RES_W-1:0] ent_src, ent_val;
  logic                    ent_take;

  assign is_digit = (key <= 4'd9);
  assign is_eq    = (key == KEY_EQ);
  assign key_op   = key_to_op(key);

  // Digit entry on whichever operand is open; leading zeros and excess digits are absorbed
  assign ent_src  = (state == ENT_B) ? b : a;
  assign ent_take = (cnt < CNT_W'(ENT_DIGITS)) && !((ent_src == '0) && (key == 4'd0));
  assign ent_val  = ent_src * RES_W'(10) + RES_W'(key);

  logic signed [WW-1:0] a_w, b_w, arith_res, div_res;
  logic [RES_W-1:0]     mag_a, mag_b, div_q;
  logic                 div_start, div_done;

  assign a_w = WW'(a);
  assign b_w = WW'(b);

  // Single-cycle operators, computed at double width so overflow is visible
  always_comb begin
    case (cur_op)
      OP_SUB:  arith_res = a_w - b_w;
      OP_MUL:  arith_res = a_w * b_w;
      default: arith_res = a_w + b_w;
    endcase
  end

  assign mag_a   = a[RES_W-1] ? -a : a;
  assign mag_b   = b[RES_W-1] ? -b : b;
  assign div_res = div_neg ? -$signed(WW'(div_q)) : $signed(WW'(div_q));

  calc_div #(.W(RES_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (clr_ev),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quotient (div_q)
  );

  // Next state and datapath updates for each accepted key or divider completion
  always_comb begin
    state_nxt      = state;
    a_nxt          = a;
    b_nxt          = b;
    cnt_nxt        = cnt;
    op_nxt         = cur_op;
    disp_nxt       = disp_val;
    pend_op_nxt    = pend_op;
    pend_chain_nxt = pend_chain;
    div_neg_nxt    = div_neg;
    div_start      = 1'b0;
    fin            = 1'b0;
    fin_res        = arith_res;
    fin_chain      = 1'b0;
    fin_op         = OP_NONE;
    if (clr_ev) begin
      state_nxt      = ENT_A;
      a_nxt          = '0;
      b_nxt          = '0;
      cnt_nxt        = '0;
      op_nxt         = OP_NONE;
      disp_nxt       = '0;
      pend_op_nxt    = OP_NONE;
      pend_chain_nxt = 1'b0;
      div_neg_nxt    = 1'b0;
    end else begin
      if (state == DIV_RUN) begin
        if (div_done) begin
          fin       = 1'b1;
          fin_res   = div_res;
          fin_chain = pend_chain;
          fin_op    = pend_op;
        end
      end else if (ev) begin
        case (state)
          ENT_A: begin
            if (is_digit) begin
              if (ent_take) begin
                a_nxt    = ent_val;
                cnt_nxt  = cnt + CNT_W'(1);
                disp_nxt = ent_val;
              end
            end else if (key_op != OP_NONE) begin
              op_nxt    = key_op;
              state_nxt = OP_WAIT;
            end
          end
          OP_WAIT: begin
            if (key_op != OP_NONE) begin
              op_nxt = key_op;
            end else if (is_digit) begin
              b_nxt     = RES_W'(key);
              cnt_nxt   = CNT_W'(1);
              disp_nxt  = RES_W'(key);
              state_nxt = ENT_B;
            end
          end
          ENT_B: begin
            if (is_digit) begin
              if (ent_take) begin
                b_nxt    = ent_val;
                cnt_nxt  = cnt + CNT_W'(1);
                disp_nxt = ent_val;
              end
            end else if (is_eq || (key_op != OP_NONE)) begin
              if (cur_op == OP_DIV) begin
                if (b == '0) begin
                  state_nxt = ERROR;
                end else begin
                  div_start      = 1'b1;
                  state_nxt      = DIV_RUN;
                  div_neg_nxt    = a[RES_W-1] ^ b[RES_W-1];
                  pend_chain_nxt = !is_eq;
                  pend_op_nxt    = key_op;
                end
              end else begin
                fin       = 1'b1;
                fin_res   = arith_res;
                fin_chain = !is_eq;
                fin_op    = key_op;
              end
            end
          end
          SHOW_RES: begin
            if (is_digit) begin
              a_nxt     = RES_W'(key);
              cnt_nxt   = (key == 4'd0) ? '0 : CNT_W'(1);
              op_nxt    = OP_NONE;
              disp_nxt  = RES_W'(key);
              state_nxt = ENT_A;
            end else if (key_op != OP_NONE) begin
              op_nxt    = key_op;
              cnt_nxt   = '0;
              state_nxt = OP_WAIT;
            end
          end
          default: ;
        endcase
      end
      if (fin) begin
        if ((fin_res > RES_LIMIT) || (fin_res < -RES_LIMIT)) begin
          state_nxt = ERROR;
        end else begin
          a_nxt    = fin_res[RES_W-1:0];
          disp_nxt = fin_res[RES_W-1:0];
          cnt_nxt  = '0;
          if (fin_chain) begin
            op_nxt    = fin_op;
            state_nxt = OP_WAIT;
          end else begin
            state_nxt = SHOW_RES;
          end
        end
      end
      if (state_nxt == ERROR) disp_nxt = '0;
    end
    err_nxt  = (state_nxt == ERROR);
    busy_nxt = (state_nxt == DIV_RUN);
  end

  // State, operands and every output are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENT_A;
      a          <= '0;
      b          <= '0;
      cnt        <= '0;
      cur_op     <= OP_NONE;
      disp_val   <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      key_drop   <= 1'b0;
      pend_op    <= OP_NONE;
      pend_chain <= 1'b0;
      div_neg    <= 1'b0;
    end else begin
      state      <= state_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      cnt        <= cnt_nxt;
      cur_op     <= op_nxt;
      disp_val   <= disp_nxt;
      err        <= err_nxt;
      busy       <= busy_nxt;
      key_drop   <= drop_nxt;
      pend_op    <= pend_op_nxt;
      pend_chain <= pend_chain_nxt;
      div_neg    <= div_neg_nxt;
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: scenario-driven bench for calc_engine. Expected results are
// queued as keys are pressed and compared when the engine produces them.
module tb_calc_engine;
  import calc_pkg::*;

  localparam int RES_W = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [3:0]              key_val = 4'd0;
  logic                    key_pressed = 1'b0;
  logic signed [RES_W-1:0] disp_val;
  logic [2:0]              cur_op;
  logic                    err;
  logic                    busy;
  logic                    key_drop;

  calc_engine #(.ENT_DIGITS(4), .DISP_DIGITS(8), .RES_W(RES_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_val     (key_val),
    .key_pressed (key_pressed),
    .disp_val    (disp_val),
    .cur_op      (cur_op),
    .err         (err),
    .busy        (busy),
    .key_drop    (key_drop)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic signed [RES_W-1:0] disp;
    logic [2:0]              op;
    logic                    err;
    logic                    busy;
    logic                    drop;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // One-cycle key strobe; returns 1 time unit after the sampling edge
  task automatic applyStimulus(input logic [3:0] k);
    key_val     = k;
    key_pressed = 1'b1;
    @(posedge clk);
    #1;
    key_pressed = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count sampled cycles with busy high, bounded so a stuck divider cannot hang the run
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    key_val     = 4'd7;
    key_pressed = 1'b1;
    @(posedge clk);
    #1;
    key_pressed = 1'b0;
    rst         = 1'b0;
    checks++;
    if (disp_val !== '0 || cur_op !== 3'd0 || err !== 1'b0 || busy !== 1'b0 || key_drop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: got disp=%0d op=%0d err=%b busy=%b drop=%b, want all zero",
               disp_val, cur_op, err, busy, key_drop);
    end
    idle(1);
    checks++;
    if (disp_val !== '0) begin
      errors++;
      $display("[TB] FAIL reset_key_discard: got disp=%0d, want 0", disp_val);
    end
  endtask

  task automatic test_add();
    int   t_key[6];
    int   t_disp[6];
    int   t_op[6];
    exp_t e;
    t_key  = '{1, 2, KEY_ADD, 3, 4, KEY_EQ};
    t_disp = '{1, 12, 12, 3, 34, 46};
    t_op   = '{0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{disp: t_disp[i], op: 3'(t_op[i]), err: 1'b0, busy: 1'b0, drop: 1'b0});
      applyStimulus(4'(t_key[i]));
      e = sb.pop_front();
      checks++;
      if (disp_val !== e.disp || cur_op !== e.op || err !== e.err || busy !== e.busy || key_drop !== e.drop) begin
        errors++;
        $display("[TB] FAIL add step %0d: got disp=%0d op=%0d err=%b busy=%b drop=%b, want disp=%0d op=%0d err=%b busy=%b drop=%b",
                 i, disp_val, cur_op, err, busy, key_drop, e.disp, e.op, e.err, e.busy, e.drop);
      end
    end
  endtask

  task automatic test_div();
    int   t_key[10];
    int   t_disp[10];
    int   t_op[10];
    int   t_div[10];
    int   cyc;
    exp_t e;
    t_key  = '{7, KEY_DIV, 2, KEY_EQ, KEY_SUB, 9, KEY_EQ, KEY_DIV, 4, KEY_EQ};
    t_disp = '{7, 7, 2, 3, 3, 9, -6, -6, 4, -1};
    t_op   = '{0, 4, 4, 4, 2, 2, 2, 4, 4, 4};
    t_div  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{disp: t_disp[i], op: 3'(t_op[i]), err: 1'b0, busy: 1'b0, drop: 1'b0});
      applyStimulus(4'(t_key[i]));
      if (t_div[i] != 0) begin
        wait_busy(cyc);
        checks++;
        if (cyc != RES_W) begin
          errors++;
          $display("[TB] FAIL div_busy step %0d: busy lasted %0d cycles, want %0d", i, cyc, RES_W);
        end
      end
      e = sb.pop_front();
      checks++;
      if (disp_val !== e.disp || cur_op !== e.op || err !== e.err || busy !== e.busy || key_drop !== e.drop) begin
        errors++;
        $display("[TB] FAIL div step %0d: got disp=%0d op=%0d err=%b busy=%b drop=%b, want disp=%0d op=%0d err=%b busy=%b drop=%b",
                 i, disp_val, cur_op, err, busy, key_drop, e.disp, e.op, e.err, e.busy, e.drop);
      end
    end
  endtask

  task automatic test_div_zero();
    int   t_key[6];
    int   t_disp[6];
    int   t_op[6];
    int   t_err[6];
    exp_t e;
    t_key  = '{5, KEY_DIV, 0, KEY_EQ, 3, KEY_CLR};
    t_disp = '{5, 5, 0, 0, 0, 0};
    t_op   = '{0, 4, 4, 4, 4, 0};
    t_err  = '{0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{disp: t_disp[i], op: 3'(t_op[i]), err: (t_err[i] != 0), busy: 1'b0, drop: 1'b0});
      applyStimulus(4'(t_key[i]));
      e = sb.pop_front();
      checks++;
      if (disp_val !== e.disp || cur_op !== e.op || err !== e.err || busy !== e.busy || key_drop !== e.drop) begin
        errors++;
        $display("[TB] FAIL div_zero step %0d: got disp=%0d op=%0d err=%b busy=%b drop=%b, want disp=%0d op=%0d err=%b busy=%b drop=%b",
                 i, disp_val, cur_op, err, busy, key_drop, e.disp, e.op, e.err, e.busy, e.drop);
      end
    end
  endtask

  task automatic test_overflow();
    int   t_key[14];
    int   t_disp[14];
    int   t_op[14];
    int   t_err[14];
    exp_t e;
    t_key  = '{9, 9, 9, 9, KEY_MUL, 9, 9, 9, 9, KEY_EQ, KEY_MUL, 2, KEY_EQ, KEY_CLR};
    t_disp = '{9, 99, 999, 9999, 9999, 9, 99, 999, 9999, 99980001, 99980001, 2, 0, 0};
    t_op   = '{0, 0, 0, 0, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0};
    t_err  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 14; i++) begin
      sb.push_back('{disp: t_disp[i], op: 3'(t_op[i]), err: (t_err[i] != 0), busy: 1'b0, drop: 1'b0});
      applyStimulus(4'(t_key[i]));
      e = sb.pop_front();
      checks++;
      if (disp_val !== e.disp || cur_op !== e.op || err !== e.err || busy !== e.busy || key_drop !== e.drop) begin
        errors++;
        $display("[TB] FAIL overflow step %0d: got disp=%0d op=%0d err=%b busy=%b drop=%b, want disp=%0d op=%0d err=%b busy=%b drop=%b",
                 i, disp_val, cur_op, err, busy, key_drop, e.disp, e.op, e.err, e.busy, e.drop);
      end
    end
  endtask

  task automatic test_chain();
    int   t_key[9];
    int   t_disp[9];
    int   t_op[9];
    exp_t e;
    t_key  = '{0, 1, 2, 3, 4, 5, KEY_ADD, 1, KEY_ADD};
    t_disp = '{0, 1, 12, 123, 1234, 1234, 1234, 1, 1235};
    t_op   = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{disp: t_disp[i], op: 3'(t_op[i]), err: 1'b0, busy: 1'b0, drop: 1'b0});
      applyStimulus(4'(t_key[i]));
      e = sb.pop_front();
      checks++;
      if (disp_val !== e.disp || cur_op !== e.op || err !== e.err || busy !== e.busy || key_drop !== e.drop) begin
        errors++;
        $display("[TB] FAIL chain step %0d: got disp=%0d op=%0d err=%b busy=%b drop=%b, want disp=%0d op=%0d err=%b busy=%b drop=%b",
                 i, disp_val, cur_op, err, busy, key_drop, e.disp, e.op, e.err, e.busy, e.drop);
      end
    end
  endtask

  // A digit pressed mid-divide: dropped without the queue, replayed with it
  task automatic test_busy_key();
    int   cyc;
    exp_t e;
    logic want_drop;
`ifdef CALC_KEY_FIFO_EN
    want_drop = 1'b0;
`else
    want_drop = 1'b1;
`endif
    applyStimulus(KEY_CLR);
    applyStimulus(4'd9);
    applyStimulus(KEY_DIV);
    applyStimulus(4'd3);
    sb.push_back('{disp: 3, op: OP_DIV, err: 1'b0, busy: 1'b0, drop: 1'b0});
    applyStimulus(KEY_EQ);
    idle(2);
    applyStimulus(4'd4);
    checks++;
    if (key_drop !== want_drop || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_key_drop: got drop=%b busy=%b, want drop=%b busy=1", key_drop, busy, want_drop);
    end
    idle(1);
    checks++;
    if (key_drop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_key_pulse: got drop=%b, want 0", key_drop);
    end
    wait_busy(cyc);
    checks++;
    if (cyc != RES_W - 4) begin
      errors++;
      $display("[TB] FAIL busy_key_remaining: got %0d busy cycles, want %0d", cyc, RES_W - 4);
    end
    e = sb.pop_front();
    checks++;
    if (disp_val !== e.disp || cur_op !== e.op || err !== e.err || busy !== e.busy) begin
      errors++;
      $display("[TB] FAIL busy_key_result: got disp=%0d op=%0d err=%b busy=%b, want disp=%0d op=%0d err=%b busy=%b",
               disp_val, cur_op, err, busy, e.disp, e.op, e.err, e.busy);
    end
`ifdef CALC_KEY_FIFO_EN
    idle(1);
    checks++;
    if (disp_val !== 4 || cur_op !== OP_NONE) begin
      errors++;
      $display("[TB] FAIL busy_key_replay: got disp=%0d op=%0d, want disp=4 op=0", disp_val, cur_op);
    end
`endif
  endtask

  // 'C' in the middle of a divide returns to the reset state and stays there
  task automatic test_clear_mid_div();
    exp_t e;
    applyStimulus(KEY_CLR);
    applyStimulus(4'd8);
    applyStimulus(KEY_DIV);
    applyStimulus(4'd2);
    applyStimulus(KEY_EQ);
    idle(4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_pre_busy: got busy=%b, want 1", busy);
    end
    applyStimulus(KEY_CLR);
    checks++;
    if (busy !== 1'b0 || disp_val !== '0 || cur_op !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_mid_div: got busy=%b disp=%0d op=%0d err=%b, want all zero",
               busy, disp_val, cur_op, err);
    end
    idle(40);
    checks++;
    if (busy !== 1'b0 || disp_val !== '0) begin
      errors++;
      $display("[TB] FAIL clear_no_leak: got busy=%b disp=%0d, want busy=0 disp=0", busy, disp_val);
    end
    applyStimulus(4'd6);
    applyStimulus(KEY_ADD);
    applyStimulus(4'd1);
    sb.push_back('{disp: 7, op: OP_ADD, err: 1'b0, busy: 1'b0, drop: 1'b0});
    applyStimulus(KEY_EQ);
    e = sb.pop_front();
    checks++;
    if (disp_val !== e.disp || cur_op !== e.op || err !== e.err || busy !== e.busy) begin
      errors++;
      $display("[TB] FAIL clear_then_add: got disp=%0d op=%0d err=%b busy=%b, want disp=%0d op=%0d err=%b busy=%b",
               disp_val, cur_op, err, busy, e.disp, e.op, e.err, e.busy);
    end
  endtask

  initial begin
    $display("[TB] calc_engine bench start");
    test_reset();
    test_add();
    test_div();
    test_div_zero();
    test_overflow();
    test_chain();
    test_busy_key();
    test_clear_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
- Consumer of the keypad key-event stream (key_val/key_pressed single-cycle pulse).
- Accumulates decimal operands, applies + - * / on operator or '=', drives a signed binary value to the display path.
- Sits between the keypad decoder and the 7-segment formatter, in the same 50 MHz domain.

Parameters:
- ENT_DIGITS, 4, max decimal digits per entered operand (max 9999).
- DISP_DIGITS, 8, max result magnitude 10^DISP_DIGITS-1; beyond that is an overflow error.
- RES_W, 32, width of the signed two's-complement operand/result registers.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- key_val  in  4  key code: 0-9 digit, 10 '/', 11 'C', 12 '+', 13 '-', 14 '*', 15 '='.
- key_pressed  in  1  one-cycle strobe qualifying key_val.
- disp_val  out  RES_W  signed value to display.
- cur_op  out  3  latched operator: 0 none, 1 +, 2 -, 3 *, 4 /.
- err  out  1  error indicator (divide by zero or overflow).
- busy  out  1  divider running.
- key_drop  out  1  one-cycle pulse when an accepted strobe is discarded.

Behaviour:
- Reset: rst=1 sampled at a clk edge sets a=b=0, digit count 0, cur_op=0, state ENT_A. Outputs: disp_val=0, err=0, busy=0, key_drop=0.
- All outputs are registered. A strobe at edge t is reflected at t+1.
- States: ENT_A, OP_WAIT, ENT_B, DIV_RUN, SHOW_RES, ERROR.
- Digit entry:
  - Operand update is a = a*10 + d, and disp_val follows the operand being entered.
  - A leading 0 on a zero operand does not advance the digit count.
  - Digits beyond ENT_DIGITS are ignored silently (no key_drop).
- ENT_A:
  - Digit updates a.
  - Operator latches cur_op and goes to OP_WAIT.
  - '=' has no effect.
- OP_WAIT:
  - Another operator replaces cur_op.
  - Digit sets b=d, count=1, goes to ENT_B.
  - '=' has no effect.
- ENT_B:
  - Digit updates b.
  - '=' evaluates a op b.
  - An operator evaluates a op b, then result→a, the new operator→cur_op, and the state goes to OP_WAIT (chained).
- Evaluation:
  - +, -, * complete in one cycle.
  - The product is formed at 2*RES_W width before the range check.
  - '/' with b=0 goes to ERROR.
  - '/' otherwise enters DIV_RUN. busy is high for exactly RES_W cycles starting t+1. Result appears and busy falls at t+RES_W+1.
- Division rule: magnitude restoring division, truncation toward zero, quotient sign = sign(a) xor sign(b).
- Result range: |result| > 10^DISP_DIGITS-1 goes to ERROR. Otherwise disp_val=result and a=result.
- After evaluation, '=' goes to SHOW_RES; the chained-operator path goes to OP_WAIT.
- SHOW_RES:
  - Digit starts a fresh A (a=d, cur_op=0, state ENT_A).
  - Operator reuses the result as a and goes to OP_WAIT.
  - '=' is ignored.
- ERROR: err=1, disp_val=0. Every key except 'C' is ignored.
- 'C': in any state, including mid-DIV_RUN, the next cycle equals the reset state. The divider is aborted and busy drops at t+1.
- Busy handling: during DIV_RUN, non-'C' strobes pulse key_drop and are discarded. Any strobe while rst=1 is discarded.

Optional Feature:
- Macro: CALC_KEY_FIFO_EN.
- Defined: a 2-entry key queue captures non-'C' strobes arriving while busy=1.
  - Queued keys are replayed one per cycle after busy falls, in arrival order.
  - A third queued key pulses key_drop and is discarded.
  - 'C' bypasses the queue and flushes it.
- Undefined: no queue. Non-'C' strobes during busy pulse key_drop.

Decomposition:
- Shared package calc_pkg: key code constants (KEY_DIV=10, KEY_CLR=11, KEY_ADD=12, KEY_SUB=13, KEY_MUL=14, KEY_EQ=15), state enum, cur_op encoding constants.
- Sub-module calc_div: unsigned restoring divider, RES_W-cycle latency, with start/abort/done handshake. The engine handles signs.

Test Plan:
- Keys 1,2,+,3,4,'=' → disp_val 12, then 34, then 46 one cycle after '='; cur_op=1; err=0.
- Keys 7,'/',2,'=' → busy high exactly 32 cycles, disp_val=3; then '-',9,'=' → -6; then '/',4,'=' → -1 (truncation toward zero).
- Keys 5,'/',0,'=' → err=1, disp_val=0; digit 3 ignored; 'C' → err=0, disp_val=0, cur_op=0.
- 9999 '*' 9999 '=' → 99980001 within range; then '*',2,'=' → err=1 (overflow).
- Keys 1,2,3,4,5 → disp_val 1234 (fifth digit ignored, no key_drop); '+',1,'+' chains → disp_val 1235, cur_op=1.
- During DIV_RUN press 4: key_drop pulse (FIFO off) or replay after busy (FIFO on); 'C' mid-divide → busy=0 next cycle, state reset.
